// File: rtl/ssd_scan.sv
// Two-digit multiplexed seven-segment scanner with dead-time gaps and per-frame input snapshot.
// Optional leading-zero blanking of the tens digit: define SSD_SCAN_LZB_EN.
module ssd_scan #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       ssd_scan_clk,
  input  logic       ssd_scan_rst,
  input  logic       ssd_scan_en,
  input  logic       ssd_scan_sel,
  input  logic [3:0] ssd_scan_d0,
  input  logic [3:0] ssd_scan_d1,
  output logic [6:0] ssd_scan_seg,
  output logic [3:0] ssd_scan_an,
  output logic       ssd_scan_frame
);
  localparam int SW = $clog2(REFRESH_DIV);
  localparam logic [SW-1:0] SLOT_LAST = SW'(REFRESH_DIV - 2);
  localparam logic [6:0] BLANK = 7'b1111111;
`ifdef SSD_SCAN_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  typedef enum logic [1:0] {DIG0, GAP0, DIG1, GAP1} state_t;

  state_t        state;
  logic [SW-1:0] slot;
  logic [3:0]    q0, q1;
  logic          qsel;

  function automatic logic [6:0] dec(input logic [3:0] d, input logic hex);
    logic [6:0] s;
    case (d)
      4'd0:  s = 7'b1000000;
      4'd1:  s = 7'b1111001;
      4'd2:  s = 7'b0100100;
      4'd3:  s = 7'b0110000;
      4'd4:  s = 7'b0011001;
      4'd5:  s = 7'b0010010;
      4'd6:  s = 7'b0000010;
      4'd7:  s = 7'b1111000;
      4'd8:  s = 7'b0000000;
      4'd9:  s = 7'b0010000;
      4'd10: s = 7'b0001000;
      4'd11: s = 7'b0000011;
      4'd12: s = 7'b1000110;
      4'd13: s = 7'b0100001;
      4'd14: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    if (!hex && d > 4'd9) s = BLANK;
    return s;
  endfunction

  function automatic logic [6:0] tens_seg(input logic [3:0] d, input logic hex);
    return (LZB && d == 4'd0) ? BLANK : dec(d, hex);
  endfunction

  // Outputs are registered from the state being entered, so they line up with it cycle-for-cycle.
  always_ff @(posedge ssd_scan_clk or negedge ssd_scan_rst) begin
    if (!ssd_scan_rst) begin
      state          <= GAP1;
      slot           <= '0;
      q0             <= 4'd0;
      q1             <= 4'd0;
      qsel           <= 1'b0;
      ssd_scan_an    <= 4'b1111;
      ssd_scan_seg   <= BLANK;
      ssd_scan_frame <= 1'b0;
    end else if (!ssd_scan_en) begin
      ssd_scan_an    <= 4'b1111;
      ssd_scan_seg   <= BLANK;
      ssd_scan_frame <= 1'b0;
    end else begin
      ssd_scan_frame <= 1'b0;
      case (state)
        DIG0: begin
          if (slot == SLOT_LAST) begin
            state        <= GAP0;
            slot         <= '0;
            ssd_scan_an  <= 4'b1111;
            ssd_scan_seg <= BLANK;
          end else begin
            slot         <= slot + 1'b1;
            ssd_scan_an  <= 4'b1110;
            ssd_scan_seg <= dec(q0, qsel);
          end
        end
        GAP0: begin
          state        <= DIG1;
          slot         <= '0;
          ssd_scan_an  <= 4'b1101;
          ssd_scan_seg <= tens_seg(q1, qsel);
        end
        DIG1: begin
          if (slot == SLOT_LAST) begin
            state        <= GAP1;
            slot         <= '0;
            ssd_scan_an  <= 4'b1111;
            ssd_scan_seg <= BLANK;
          end else begin
            slot         <= slot + 1'b1;
            ssd_scan_an  <= 4'b1101;
            ssd_scan_seg <= tens_seg(q1, qsel);
          end
        end
        default: begin
          // Frame boundary: snapshot both digits and the mode together.
          state          <= DIG0;
          slot           <= '0;
          q0             <= ssd_scan_d0;
          q1             <= ssd_scan_d1;
          qsel           <= ssd_scan_sel;
          ssd_scan_an    <= 4'b1110;
          ssd_scan_seg   <= dec(ssd_scan_d0, ssd_scan_sel);
          ssd_scan_frame <= 1'b1;
        end
      endcase
    end
  end
endmodule
